// File: rtl/sparce_skip_sequencer_pkg.sv
// Shared types and constants for the SparCE skip sequencer slice.
// State encoding, register-index width and cooldown counter width live here.
package sparce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        REQ,
        COOLDOWN
    } sparce_skip_state_t;

    localparam int NUM_REGS_DFLT = 32;
    localparam int REG_IDX_W     = $clog2(NUM_REGS_DFLT);
    localparam int COOLDOWN_W    = 4;

endpackage

// File: rtl/sparce_skip_sequencer_if.sv
// Bundle of lookup, sparsity, redirect and counter signals between the SVT/pipeline side
// and the skip sequencer; master drives lookups/acks, slave is the sequencer.
interface sparce_skip_sequencer_if
    import sparce_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DFLT,
    parameter int ADDR_W   = 32,
    parameter int CNT_W    = 32
);
    localparam int RS_W = $clog2(NUM_REGS);

    logic                enable;
    logic                lookup_valid;
    logic [ADDR_W-1:0]   lookup_pc;
    logic                svt_hit;
    logic [RS_W-1:0]     svt_rs;
    logic [ADDR_W-1:0]   svt_target;
    logic [NUM_REGS-1:0] sprf_zero;
    logic [NUM_REGS-1:0] rd_inflight;
    logic                flush_abort;
    logic                skip_ack;
    logic                clr_count;
    logic                skip_req;
    logic [ADDR_W-1:0]   skip_pc;
    logic                busy;
    logic [CNT_W-1:0]    skip_count;

    modport master (
        output enable, lookup_valid, lookup_pc, svt_hit, svt_rs, svt_target,
               sprf_zero, rd_inflight, flush_abort, skip_ack, clr_count,
        input  skip_req, skip_pc, busy, skip_count
    );

    modport slave (
        input  enable, lookup_valid, lookup_pc, svt_hit, svt_rs, svt_target,
               sprf_zero, rd_inflight, flush_abort, skip_ack, clr_count,
        output skip_req, skip_pc, busy, skip_count
    );

endinterface

// File: rtl/sparce_sat_counter.sv
// Saturating up-counter with a clear that takes priority over increment.
module sparce_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sparce_skip_sequencer.sv
// Control FSM that turns a qualified SVT hit into a single outstanding fetch redirect
// and counts the redirects the fetch unit actually commits.
module sparce_skip_sequencer
    import sparce_pkg::*;
#(
    parameter int NUM_REGS        = NUM_REGS_DFLT,
    parameter int ADDR_W          = 32,
    parameter int CNT_W           = 32,
    parameter int COOLDOWN_CYCLES = 1
) (
    input logic                    CLK,
    input logic                    RST,
    sparce_skip_sequencer_if.slave bus
);

    localparam int                    RS_W          = $clog2(NUM_REGS);
    localparam logic [COOLDOWN_W-1:0] COOLDOWN_LOAD = COOLDOWN_W'(COOLDOWN_CYCLES);
    localparam logic [COOLDOWN_W-1:0] COOL_ONE      = COOLDOWN_W'(1);

    sparce_skip_state_t    state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [ADDR_W-1:0]     target_q, target_d;
    logic [RS_W-1:0]       rs_q, rs_d;
    logic                  skip_req_q, skip_req_d;
    logic [ADDR_W-1:0]     skip_pc_q, skip_pc_d;
    logic                  busy_q, busy_d;
    logic [COOLDOWN_W-1:0] cool_q, cool_d;
    logic                  zero_ok;
    logic                  qualify;
    logic                  count_inc;

    // Register r0 is hardwired to zero, so its SpRF bit is never consulted.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        rs_d       = rs_q;
        skip_req_d = skip_req_q;
        skip_pc_d  = skip_pc_q;
        cool_d     = cool_q;
        count_inc  = 1'b0;
        zero_ok    = (rs_q == '0) || bus.sprf_zero[rs_q];
        qualify    = bus.enable && zero_ok && !bus.rd_inflight[rs_q] && (target_q > pc_q);

        unique case (state_q)
            IDLE: begin
                if (!bus.flush_abort && bus.enable && bus.lookup_valid && bus.svt_hit) begin
                    pc_d     = bus.lookup_pc;
                    rs_d     = bus.svt_rs;
                    target_d = bus.svt_target;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (bus.flush_abort || !qualify) begin
                    state_d = IDLE;
                end else begin
                    state_d    = REQ;
                    skip_req_d = 1'b1;
                    skip_pc_d  = target_q;
                end
            end
            REQ: begin
                // A flush kills the redirect even if the fetch unit acks in the same cycle.
                if (bus.flush_abort) begin
                    state_d    = IDLE;
                    skip_req_d = 1'b0;
                end else if (bus.skip_ack) begin
                    skip_req_d = 1'b0;
                    count_inc  = 1'b1;
                    cool_d     = COOLDOWN_LOAD;
                    state_d    = (COOLDOWN_CYCLES == 0) ? IDLE : COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (bus.flush_abort || (cool_q <= COOL_ONE)) begin
                    state_d = IDLE;
                end else begin
                    cool_d = cool_q - COOL_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            target_q   <= '0;
            rs_q       <= '0;
            skip_req_q <= 1'b0;
            skip_pc_q  <= '0;
            busy_q     <= 1'b0;
            cool_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            rs_q       <= rs_d;
            skip_req_q <= skip_req_d;
            skip_pc_q  <= skip_pc_d;
            busy_q     <= busy_d;
            cool_q     <= cool_d;
        end
    end

    sparce_sat_counter #(
        .WIDTH (CNT_W)
    ) u_skip_counter (
        .clk   (CLK),
        .rst   (RST),
        .clr   (bus.clr_count),
        .inc   (count_inc),
        .count (bus.skip_count)
    );

    assign bus.skip_req = skip_req_q;
    assign bus.skip_pc  = skip_pc_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_sparce_skip_sequencer.sv
// Bench for the skip sequencer: two instances (4-bit counter with one cooldown cycle,
// 32-bit counter with no cooldown) share stimulus and are each checked against a reference model.
module tb_sparce_skip_sequencer;

    logic        CLK;
    logic        RST;
    logic        enable;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        svt_hit;
    logic [4:0]  svt_rs;
    logic [31:0] svt_target;
    logic [31:0] sprf_zero;
    logic [31:0] rd_inflight;
    logic        flush_abort;
    logic        skip_ack;
    logic        clr_count;

    int n_cmp = 0;
    int n_bad = 0;

    sparce_skip_sequencer_if #(.NUM_REGS(32), .ADDR_W(32), .CNT_W(4))  if0 ();
    sparce_skip_sequencer_if #(.NUM_REGS(32), .ADDR_W(32), .CNT_W(32)) if1 ();

    assign if0.enable = enable;        assign if1.enable = enable;
    assign if0.lookup_valid = lookup_valid; assign if1.lookup_valid = lookup_valid;
    assign if0.lookup_pc = lookup_pc;  assign if1.lookup_pc = lookup_pc;
    assign if0.svt_hit = svt_hit;      assign if1.svt_hit = svt_hit;
    assign if0.svt_rs = svt_rs;        assign if1.svt_rs = svt_rs;
    assign if0.svt_target = svt_target; assign if1.svt_target = svt_target;
    assign if0.sprf_zero = sprf_zero;  assign if1.sprf_zero = sprf_zero;
    assign if0.rd_inflight = rd_inflight; assign if1.rd_inflight = rd_inflight;
    assign if0.flush_abort = flush_abort; assign if1.flush_abort = flush_abort;
    assign if0.skip_ack = skip_ack;    assign if1.skip_ack = skip_ack;
    assign if0.clr_count = clr_count;  assign if1.clr_count = clr_count;

    sparce_skip_sequencer #(
        .NUM_REGS(32), .ADDR_W(32), .CNT_W(4), .COOLDOWN_CYCLES(1)
    ) dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (if0)
    );

    sparce_skip_sequencer #(
        .NUM_REGS(32), .ADDR_W(32), .CNT_W(32), .COOLDOWN_CYCLES(0)
    ) dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (if1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: a pending check, an open redirect, or remaining cooldown cycles.
    typedef struct {
        bit              chk;
        bit              req;
        int              cool;
        logic [31:0]     pc;
        logic [31:0]     tgt;
        int              rs;
        logic [31:0]     spc;
        bit              spc_known;
        longint unsigned cnt;
    } mdl_t;

    mdl_t m0;
    mdl_t m1;

    function automatic mdl_t model_step(mdl_t m, int cd, int w);
        mdl_t            n = m;
        longint unsigned cmax = (64'd1 << w) - 64'd1;
        bit              acked;
        if (RST) begin
            n = '{default: 0};
            n.spc_known = 1'b1;
            return n;
        end
        acked = m.req && skip_ack && !flush_abort;
        if (clr_count) n.cnt = 0;
        else if (acked && m.cnt < cmax) n.cnt = m.cnt + 1;
        if (flush_abort) begin
            n.chk = 1'b0;
            n.cool = 0;
            if (m.req) n.spc_known = 1'b0;
            n.req = 1'b0;
        end else if (m.chk) begin
            n.chk = 1'b0;
            if (enable && (m.rs == 0 || sprf_zero[m.rs]) && !rd_inflight[m.rs] && m.tgt > m.pc) begin
                n.req = 1'b1;
                n.spc = m.tgt;
                n.spc_known = 1'b1;
            end
        end else if (m.req) begin
            if (skip_ack) begin
                n.req = 1'b0;
                n.cool = cd;
                n.spc_known = 1'b0;
            end
        end else if (m.cool > 0) begin
            n.cool = m.cool - 1;
        end else if (enable && lookup_valid && svt_hit) begin
            n.chk = 1'b1;
            n.pc  = lookup_pc;
            n.rs  = int'(svt_rs);
            n.tgt = svt_target;
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("d0_skip_req",   64'(if0.skip_req),   64'(m0.req));
        checkOutput("d0_busy",       64'(if0.busy),       64'(m0.chk || m0.req || m0.cool > 0));
        checkOutput("d0_skip_count", 64'(if0.skip_count), 64'(m0.cnt));
        if (m0.spc_known) checkOutput("d0_skip_pc", 64'(if0.skip_pc), 64'(m0.spc));
        checkOutput("d1_skip_req",   64'(if1.skip_req),   64'(m1.req));
        checkOutput("d1_busy",       64'(if1.busy),       64'(m1.chk || m1.req || m1.cool > 0));
        checkOutput("d1_skip_count", 64'(if1.skip_count), 64'(m1.cnt));
        if (m1.spc_known) checkOutput("d1_skip_pc", 64'(if1.skip_pc), 64'(m1.spc));
    endtask

    task automatic tick();
        @(posedge CLK);
        m0 = model_step(m0, 1, 4);
        m1 = model_step(m1, 0, 32);
        #1;
        checkAll();
    endtask

    task automatic setIdle();
        RST          = 1'b0;
        enable       = 1'b1;
        lookup_valid = 1'b0;
        svt_hit      = 1'b0;
        flush_abort  = 1'b0;
        skip_ack     = 1'b0;
        clr_count    = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [4:0] rs, input logic [31:0] tgt);
        lookup_valid = 1'b1;
        svt_hit      = 1'b1;
        lookup_pc    = pc;
        svt_rs       = rs;
        svt_target   = tgt;
        tick();
        lookup_valid = 1'b0;
        svt_hit      = 1'b0;
    endtask

    task automatic runLookup(input logic [31:0] pc, input logic [4:0] rs, input logic [31:0] tgt,
                             input int ack_wait);
        applyStimulus(pc, rs, tgt);
        tick();
        repeat (ack_wait) tick();
        skip_ack = 1'b1;
        tick();
        skip_ack = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        m0 = '{default: 0};
        m1 = '{default: 0};
        setIdle();
        RST         = 1'b1;
        lookup_pc   = '0;
        svt_rs      = '0;
        svt_target  = '0;
        sprf_zero   = 32'h0000_0020;
        rd_inflight = '0;
        repeat (2) tick();
        RST = 1'b0;
        tick();

        $display("[TB] legal skip with delayed ack");
        runLookup(32'h100, 5'd5, 32'h120, 2);

        $display("[TB] rejected lookups and r0 override");
        sprf_zero = '0;
        runLookup(32'h100, 5'd5, 32'h120, 0);
        sprf_zero = 32'h0000_0020;
        rd_inflight = 32'h0000_0020;
        runLookup(32'h100, 5'd5, 32'h120, 0);
        rd_inflight = '0;
        runLookup(32'h100, 5'd5, 32'h100, 0);
        runLookup(32'h100, 5'd5, 32'h0F0, 0);
        sprf_zero = '0;
        runLookup(32'h100, 5'd0, 32'h140, 1);
        sprf_zero = 32'h0000_0020;

        $display("[TB] flush in REQ, alone and with ack");
        applyStimulus(32'h300, 5'd5, 32'h380);
        tick();
        flush_abort = 1'b1;
        tick();
        flush_abort = 1'b0;
        runLookup(32'h400, 5'd5, 32'h480, 0);
        applyStimulus(32'h300, 5'd5, 32'h380);
        tick();
        flush_abort = 1'b1;
        skip_ack    = 1'b1;
        tick();
        flush_abort = 1'b0;
        skip_ack    = 1'b0;
        runLookup(32'h500, 5'd5, 32'h580, 0);

        $display("[TB] lookups while busy");
        lookup_valid = 1'b1;
        svt_hit      = 1'b1;
        lookup_pc    = 32'h600;
        svt_rs       = 5'd5;
        svt_target   = 32'h640;
        repeat (3) tick();
        skip_ack = 1'b1;
        tick();
        skip_ack = 1'b0;
        tick();
        lookup_valid = 1'b0;
        svt_hit      = 1'b0;
        repeat (3) tick();
        skip_ack = 1'b1;
        tick();
        skip_ack = 1'b0;
        repeat (2) tick();

        $display("[TB] counter saturation and clear priority");
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        for (int i = 0; i < 16; i++) runLookup(32'h700, 5'd5, 32'h740, 0);
        applyStimulus(32'h700, 5'd5, 32'h740);
        tick();
        skip_ack  = 1'b1;
        clr_count = 1'b1;
        tick();
        skip_ack  = 1'b0;
        clr_count = 1'b0;
        tick();

        $display("[TB] reset during REQ");
        applyStimulus(32'h800, 5'd5, 32'h900);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            RST          = ($urandom_range(0, 299) == 0);
            enable       = ($urandom_range(0, 7) != 0);
            lookup_valid = $urandom_range(0, 1) == 1;
            svt_hit      = $urandom_range(0, 3) != 0;
            lookup_pc    = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 63) * 4);
            svt_target   = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 63) * 4);
            svt_rs       = 5'($urandom_range(0, 31));
            sprf_zero    = $urandom() | $urandom();
            rd_inflight  = $urandom() & $urandom() & $urandom();
            flush_abort  = ($urandom_range(0, 15) == 0);
            skip_ack     = $urandom_range(0, 1) == 1;
            clr_count    = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sparce_skip_sequencer.md
Name: sparce_skip_sequencer

Overview:
- Control FSM for the SparCE skip datapath.
- Sits between the Sparsity Value Table (SVT) lookup and the pipeline hazard/fetch unit.
- On an SVT hit, it checks the sparsity register file (SpRF) bit of the governing register and the in-flight write hazards. When the skip is legal, it issues a fetch redirect to the skip target through a req/ack handshake.
- It also keeps a saturating count of committed skips for performance monitoring.

Parameters:
- NUM_REGS, 32, number of architectural integer registers; sets the width of the SpRF and in-flight vectors.
- ADDR_W, 32, PC and target width.
- CNT_W, 32, width of the skip counter.
- COOLDOWN_CYCLES, 1, number of idle cycles after a committed skip before a new lookup is accepted. Legal range is 0..15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- enable  in  1  sparsity optimisation enabled
- lookup_valid  in  1  SVT lookup result valid this cycle
- lookup_pc  in  ADDR_W  PC of the instruction that was looked up
- svt_hit  in  1  SVT entry matched lookup_pc
- svt_rs  in  $clog2(NUM_REGS)  index of the register that governs the skip
- svt_target  in  ADDR_W  PC to resume at if the skip is taken
- sprf_zero  in  NUM_REGS  per-register "value is zero" bits
- rd_inflight  in  NUM_REGS  per-register "write pending in pipeline" bits
- flush_abort  in  1  pipeline flush (mispredict or exception)
- skip_ack  in  1  fetch unit accepted the redirect
- clr_count  in  1  clear skip_count
- skip_req  out  1  redirect request
- skip_pc  out  ADDR_W  redirect target
- busy  out  1  FSM not in IDLE
- skip_count  out  CNT_W  number of committed skips, saturating

Behaviour:
- Reset: state=IDLE; skip_req=0, skip_pc=0, busy=0, skip_count=0, internal latches=0. Reset overrides every other input.
- All outputs are registered. busy is high whenever state is not IDLE.
- States: IDLE, CHECK, REQ, COOLDOWN.
- IDLE: if enable && lookup_valid && svt_hit:
  - latch lookup_pc, svt_rs, svt_target;
  - go to CHECK.
  - Otherwise stay in IDLE.
- CHECK (exactly 1 cycle):
  - qualify = enable && zero_ok && !rd_inflight[rs_q] && (target_q > pc_q), using an unsigned compare. Backward or equal targets never qualify.
  - zero_ok = sprf_zero[rs_q], except that register index 0 is always treated as zero.
  - qualify=1: go to REQ, registering skip_req=1 and skip_pc=target_q.
  - qualify=0: go to IDLE with no count.
- Latency: a lookup accepted in cycle N gives CHECK in N+1 and skip_req high in N+2 at the earliest.
- REQ:
  - skip_req and skip_pc are held stable until skip_ack is sampled high.
  - enable deasserting does not retract the request. Only flush_abort or RST may drop skip_req without an ack.
  - On skip_ack: skip_req=0 next cycle, skip_count increments, go to COOLDOWN. If COOLDOWN_CYCLES=0, go to IDLE instead.
  - skip_ack sampled in any state other than REQ is ignored.
- COOLDOWN:
  - A down-counter loaded with COOLDOWN_CYCLES on entry.
  - Go to IDLE in the cycle the counter reaches 1.
  - Lookups are ignored throughout; they are dropped, not queued.
- flush_abort in CHECK, REQ or COOLDOWN: go to IDLE next cycle, skip_req=0, no count.
  - flush_abort and skip_ack in the same cycle: flush wins and no count is taken.
  - flush_abort in IDLE also blocks acceptance of a lookup presented that cycle.
- skip_count:
  - saturates at all-ones; no wrap.
  - clr_count has priority over an increment: clr_count and ack in the same cycle gives 0.
- Only one skip is outstanding at a time. New lookups arriving while busy are ignored.

Decomposition:
- sparce_pkg holds:
  - typedef sparce_skip_state_t (enum IDLE/CHECK/REQ/COOLDOWN);
  - localparam REG_IDX_W = $clog2(NUM_REGS);
  - COOLDOWN_W = 4.
- One sub-module, sparce_sat_counter. It is a parameterised-width saturating counter with clear (priority) and increment inputs, and is used for skip_count.

Test Plan:
- Legal skip: lookup_pc=0x100, svt_rs=5, svt_target=0x120, sprf_zero[5]=1, rd_inflight=0 → skip_req rises 2 cycles later with skip_pc=0x120. Hold skip_ack low for 3 cycles, then high → skip_req stays high with a stable PC until the ack, then drops; skip_count=1; busy is high through COOLDOWN (1 cycle), then low.
- Rejects: (a) sprf_zero[5]=0; (b) rd_inflight[5]=1; (c) svt_target=0x100; (d) svt_target=0x0F0 → each returns to IDLE after CHECK with skip_req never asserted and skip_count=0. Also svt_rs=0 with sprf_zero=0 → the skip is taken.
- Flush: flush_abort pulsed in REQ, once alone and once together with skip_ack → skip_req=0 next cycle, state IDLE, skip_count unchanged. A lookup presented in the following cycle is accepted.
- Busy drop: a second svt_hit lookup during CHECK, REQ or COOLDOWN → ignored; only one skip_req is issued and skip_count=1.
- Counter: with CNT_W=4, perform 16 legal skips → skip_count=15. Assert clr_count together with an ack → skip_count=0.
- Reset and parameter sweep: assert RST during REQ → all outputs 0 on the next edge. Run with COOLDOWN_CYCLES=0 → back-to-back skips are accepted on the cycle after the ack.
